// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants. Holds the receive FIFO geometry
//               defaults next to the receiver and baud-timer constants so
//               that every UART block is sized from one place.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Receiver data word width; the receive FIFO must match it.
    localparam int DBIT_DEFAULT       = 8;
    // The receive FIFO holds 2**ADDR_WIDTH_DEFAULT words.
    localparam int ADDR_WIDTH_DEFAULT = 4;

    // Receiver and baud-timer constants.
    localparam int SB_TICK_DEFAULT    = 16;  // oversample ticks per stop bit
    localparam int OVERSAMPLE         = 16;  // baud ticks per bit period

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Number of words stored by a FIFO with the given address width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_fifo_ctrl.sv
// ============================================================================
// Module      : uart_rx_fifo_ctrl
// Description : Pointer, level and flag control for the UART receive FIFO.
//               It decides whether each cycle pushes and/or pops, and it
//               keeps the level, empty and full flags registered. The sticky
//               overrun flag is built only when UART_RX_FIFO_OVERRUN_EN is
//               defined. Without it, overrun is tied low and overrun_clr is
//               ignored.
// Ports       : clk, reset_n        - clock, async active-low reset
//               wr, rd              - push / pop strobes (sampled each edge)
//               overrun_clr         - synchronous clear of overrun
//               wr_en               - write the storage array at wr_ptr
//               wr_ptr, rd_ptr      - storage addresses
//               empty, full, level  - registered occupancy
//               overrun             - sticky lost-word flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  overrun_clr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH:0] C_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] C_LVL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q,  level_d;
    logic                  empty_q,  empty_d;
    logic                  full_q,   full_d;
    logic                  push;
    logic                  pop;
    logic                  drop;

    always_comb begin
        // A full FIFO still accepts a push when a pop frees the head slot
        // in the same cycle. An empty FIFO never pops, even with wr=rd=1.
        push     = wr & (~full_q | rd);
        pop      = rd & ~empty_q;
        drop     = wr & full_q & ~rd;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + C_LVL_ONE;
            2'b01:   level_d = level_q - C_LVL_ONE;
            default: level_d = level_q;
        endcase

        // The flags come from the next level, so they stay registered and
        // always agree with level.
        empty_d  = (level_d == '0);
        full_d   = (level_d == C_DEPTH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic overrun_q, overrun_d;

    // When a drop and a clear happen in the same cycle, the drop wins and
    // the new loss stays visible.
    always_comb begin
        overrun_d = drop | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    // With overrun detection compiled out, the clear input and the drop
    // indication have no load.
    logic unused_overrun_sigs;
    assign unused_overrun_sigs = overrun_clr | drop;
    assign overrun = 1'b0;
`endif

    assign wr_en  = push;
    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign empty  = empty_q;
    assign full   = full_q;
    assign level  = level_q;

endmodule : uart_rx_fifo_ctrl

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word fall-through receive FIFO that sits between the
//               UART receiver and its consumer. This module holds the
//               storage array. Pointer and flag control is in
//               uart_rx_fifo_ctrl. Defining UART_RX_FIFO_OVERRUN_EN builds
//               in the sticky overrun flag.
// Ports       : clk, reset_n  - clock, async active-low reset
//               wr, wr_data   - push strobe and data (receiver done tick/dout)
//               rd            - pop strobe from consumer
//               rd_data       - head word, valid while empty=0
//               empty, full   - occupancy flags
//               level         - word count 0..2**ADDR_WIDTH
//               overrun       - sticky lost-word flag
//               overrun_clr   - synchronous clear of overrun
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr,
    input  logic [DBIT-1:0]     wr_data,
    input  logic                rd,
    output logic [DBIT-1:0]     rd_data,
    output logic                empty,
    output logic                full,
    output logic [ADDR_WIDTH:0] level,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int C_DEPTH = 1 << ADDR_WIDTH;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    // The storage has no reset. Words left after a reset are discarded
    // only because the pointers and level return to zero.
    logic [DBIT-1:0] mem_q [C_DEPTH];

    uart_rx_fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr          (wr),
        .rd          (rd),
        .overrun_clr (overrun_clr),
        .wr_en       (wr_en),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .overrun     (overrun)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    // First-word fall-through. The head word is read combinationally from
    // the registered read pointer.
    assign rd_data = mem_q[rd_ptr];

endmodule : uart_rx_fifo

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo. It expects
//               an overrun only when UART_RX_FIFO_OVERRUN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_OVERRUN_EN
    localparam logic C_OVR = 1'b1;
`else
    localparam logic C_OVR = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       wr;
    logic [7:0] wr_data;
    logic       rd;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic       overrun_clr;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr          (wr),
        .wr_data     (wr_data),
        .rd          (rd),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr = 1'b0; rd = 1'b0; wr_data = 8'h00; overrun_clr = 1'b0;
        step(); step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty actual=%0b expected=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full actual=%0b expected=0", full); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level actual=%0d expected=0", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun actual=%0b expected=0", overrun); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        wr = 1'b1; wr_data = 8'hAB;
        step();
        wr = 1'b0;
        checks++; if (rd_data !== 8'hAB) begin errors++; $display("FAIL single_data actual=%0h expected=ab", rd_data); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_notempty actual=%0b expected=0", empty); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level1 actual=%0d expected=1", level); end
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty actual=%0b expected=1", empty); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level0 actual=%0d expected=0", level); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; wr_data = 8'(i);
            step();
        end
        wr = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full actual=%0b expected=1", full); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level actual=%0d expected=16", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fill_no_overrun actual=%0b expected=0", overrun); end
        // 17th push is dropped
        wr = 1'b1; wr_data = 8'hFF;
        step();
        wr = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL drop_level actual=%0d expected=16", level); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL drop_head actual=%0h expected=00", rd_data); end
        checks++; if (overrun !== C_OVR) begin errors++; $display("FAIL drop_overrun actual=%0b expected=%0b", overrun, C_OVR); end
        // Idle cycle: flag is sticky
        step();
        checks++; if (overrun !== C_OVR) begin errors++; $display("FAIL overrun_sticky actual=%0b expected=%0b", overrun, C_OVR); end
        // Drop and clear together: drop wins
        wr = 1'b1; wr_data = 8'hEE; overrun_clr = 1'b1;
        step();
        wr = 1'b0;
        checks++; if (overrun !== C_OVR) begin errors++; $display("FAIL drop_and_clr actual=%0b expected=%0b", overrun, C_OVR); end
        step();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr actual=%0b expected=0", overrun); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL fill_order[%0d] actual=%0h expected=%0h", i, rd_data, 8'(i)); end
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty actual=%0b expected=1", empty); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL drain_level actual=%0d expected=0", level); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; wr_data = 8'h20 + 8'(i);
            step();
        end
        wr = 1'b1; rd = 1'b1; wr_data = 8'h55;
        step();
        wr = 1'b0; rd = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fullrw_level actual=%0d expected=16", level); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullrw_full actual=%0b expected=1", full); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullrw_overrun actual=%0b expected=0", overrun); end
        checks++; if (rd_data !== 8'h21) begin errors++; $display("FAIL fullrw_head actual=%0h expected=21", rd_data); end
        for (int i = 1; i < 16; i++) begin
            checks++; if (rd_data !== 8'h20 + 8'(i)) begin errors++; $display("FAIL fullrw_order[%0d] actual=%0h expected=%0h", i, rd_data, 8'h20 + 8'(i)); end
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL fullrw_last actual=%0h expected=55", rd_data); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL fullrw_lastlvl actual=%0d expected=1", level); end
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullrw_empty actual=%0b expected=1", empty); end
    endtask

    task automatic test_empty_cases();
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL emptypop_level actual=%0d expected=0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL emptypop_empty actual=%0b expected=1", empty); end
        wr = 1'b1; rd = 1'b1; wr_data = 8'h3C;
        step();
        wr = 1'b0; rd = 1'b0;
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL emptyrw_level actual=%0d expected=1", level); end
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL emptyrw_data actual=%0h expected=3c", rd_data); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL emptyrw_empty actual=%0b expected=0", empty); end
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] exp_d;
        int         max_lvl;
        max_lvl = 0;
        // Preload three words, then 40 simultaneous push/pop cycles
        // (over two pointer laps), then drain.
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; wr_data = 8'hA0 + 8'(i); q.push_back(wr_data);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            exp_d = q.pop_front();
            checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL wrap_data[%0d] actual=%0h expected=%0h", i, rd_data, exp_d); end
            wr = 1'b1; rd = 1'b1; wr_data = 8'(i * 7 + 5); q.push_back(wr_data);
            step();
            if (int'(level) > max_lvl) max_lvl = int'(level);
            checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL wrap_level[%0d] actual=%0d expected=%0d", i, level, q.size()); end
        end
        wr = 1'b0;
        while (q.size() > 0) begin
            exp_d = q.pop_front();
            checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL wrap_drain actual=%0h expected=%0h", rd_data, exp_d); end
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        checks++; if (max_lvl > 16) begin errors++; $display("FAIL wrap_maxlevel actual=%0d expected<=16", max_lvl); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty actual=%0b expected=1", empty); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 17; i++) begin
            wr = 1'b1; wr_data = 8'h80 + 8'(i);
            step();
        end
        wr = 1'b0;
        for (int i = 0; i < 11; i++) begin
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL prerst_level actual=%0d expected=5", level); end
        checks++; if (overrun !== C_OVR) begin errors++; $display("FAIL prerst_overrun actual=%0b expected=%0b", overrun, C_OVR); end
        // Assert reset mid-cycle during a push burst; outputs react before
        // the next clock edge.
        wr = 1'b1; wr_data = 8'h99;
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty actual=%0b expected=1", empty); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL arst_level actual=%0d expected=0", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL arst_overrun actual=%0b expected=0", overrun); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL arst_full actual=%0b expected=0", full); end
        step();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL arst_hold actual=%0d expected=0", level); end
        reset_n = 1'b1; wr = 1'b0;
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL postrst_empty actual=%0b expected=1", empty); end
        wr = 1'b1; wr_data = 8'h42;
        step();
        wr = 1'b0;
        checks++; if (rd_data !== 8'h42) begin errors++; $display("FAIL postrst_data actual=%0h expected=42", rd_data); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL postrst_level actual=%0d expected=1", level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overrun();
        test_full_rw();
        test_empty_cases();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo

`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DBIT, default 8, meaning data word width (matches receiver DBIT).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning depth = 2**ADDR_WIDTH words (16).
REQ-003 SHALL have port clk  input  1  rising-edge system clock, sole clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr  input  1  push strobe, driven by receiver rx_done_tick.
REQ-006 SHALL have port wr_data  input  DBIT  push data, driven by receiver rx_dout.
REQ-007 SHALL have port rd  input  1  pop strobe from consumer.
REQ-008 SHALL have port rd_data  output  DBIT  head word, first-word fall-through.
REQ-009 SHALL have port empty  output  1  no words stored.
REQ-010 SHALL have port full  output  1  2**ADDR_WIDTH words stored.
REQ-011 SHALL have port level  output  ADDR_WIDTH+1  current word count, 0..2**ADDR_WIDTH.
REQ-012 SHALL have port overrun  output  1  sticky lost-byte flag.
REQ-013 SHALL have port overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-014 SHALL sample wr and rd on every rising clk edge; one push/pop per strobe-cycle, strobes single-cycle or level (each high cycle counts).
REQ-015 SHALL store wr_data at write pointer when wr=1 and (full=0 or rd=1); write pointer increments mod 2**ADDR_WIDTH.
REQ-016 SHALL advance read pointer when rd=1 and empty=0; rd while empty ignored, no state change.
REQ-017 SHALL present rd_data = mem[read pointer] combinationally from registered pointer; valid whenever empty=0, value undefined-but-stable when empty=1.
REQ-018 SHALL give write-to-visible latency of 1 cycle: word pushed at edge N appears on rd_data, empty=0 after edge N.
REQ-019 SHALL on wr=1, rd=1, 0<level<max: push and pop both, level unchanged.
REQ-020 SHALL on wr=1, rd=1, full=1: pop head and push new word, level stays max, no overrun.
REQ-021 SHALL on wr=1, rd=1, empty=1: push only, level becomes 1.
REQ-022 SHALL on wr=1, rd=0, full=1: drop wr_data, memory and pointers unchanged, set overrun (see REQ-029).
REQ-023 SHALL keep level, empty, full registered and mutually consistent: empty=(level==0), full=(level==2**ADDR_WIDTH).
REQ-024 SHALL handle pointer wrap-around without data loss or order change across any number of laps.

Reset
REQ-025 SHALL on reset_n=0, asynchronously: pointers=0, level=0, empty=1, full=0, overrun=0.
REQ-026 SHALL not clear memory contents on reset; stored words are discarded logically.
REQ-027 SHALL, if reset asserts mid-burst, resume with empty FIFO on first edge after release; no partial word survives.

Configuration
REQ-028 SHALL use macro UART_RX_FIFO_OVERRUN_EN to compile overrun detection in or out.
REQ-029 SHALL with macro defined: set overrun on dropped push (REQ-022); hold until overrun_clr=1 or reset; if drop and overrun_clr in same cycle, overrun stays 1.
REQ-030 SHALL with macro undefined: overrun tied 0, overrun_clr ignored, ports still present, no flag register.

Structure
REQ-031 SHALL take DBIT and ADDR_WIDTH defaults from shared package/header uart_pkg alongside receiver/timer constants.
REQ-032 SHALL split pointer/level/flag logic into sub-module uart_rx_fifo_ctrl; storage array in uart_rx_fifo top.

Verification
REQ-033 Bench SHALL push 0xAB, pop once -> rd_data=0xAB one cycle after push, empty returns 1 after pop, level 1->0.
REQ-034 Bench SHALL push 16 words 0x00..0x0F -> full=1, level=16; 17th push 0xFF -> dropped, overrun=1; pop 16 -> 0x00..0x0F in order.
REQ-035 Bench SHALL with full FIFO assert wr=rd=1 with 0x55 -> level 16, overrun 0, head advances, 0x55 read last.
REQ-036 Bench SHALL pop on empty and wr=rd=1 on empty with 0x3C -> first: no change; second: level=1, rd_data=0x3C.
REQ-037 Bench SHALL run 40 push/pop pairs (wrap over 2 laps) -> data order intact, level never exceeds 16.
REQ-038 Bench SHALL assert reset_n=0 with level=5, overrun=1 -> empty=1, level=0, overrun=0 immediately, before next clk edge.
